// File: rtl/mfp_eic_ack_decoder.sv
// mfp_eic_ack_decoder: latches the EIC request for the core and turns the core's
// acknowledge into a one-cycle one-hot pending-flag clear pulse.
module mfp_eic_ack_decoder #(
    parameter int ICOUNT = 64,
    parameter int VW     = 6
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              irq_detect,
    input  logic [VW-1:0]     irq_number,
    input  logic [VW-1:0]     EIC_IPL,
    input  logic              EIC_IAck,
    output logic [VW-1:0]     EIC_RIPL,
    output logic [VW-1:0]     EIC_Vector,
    output logic [ICOUNT-1:0] irq_clear,
    output logic              ack_valid,
    output logic [VW-1:0]     ack_number
);

    typedef enum logic [1:0] {IDLE, REQ, ACK, WAIT} state_t;

    state_t              state_q, state_d;
    logic [VW-1:0]       ripl_q, ripl_d;
    logic [VW-1:0]       vec_q, vec_d;
    logic [ICOUNT-1:0]   clear_q, clear_d, onehot;
    logic                ackv_q, ackv_d;
    logic [VW-1:0]       ackn_q, ackn_d;
    logic                eligible;

    assign eligible = irq_detect && (irq_number != '0) && (irq_number > EIC_IPL);

    // Latched numbers beyond ICOUNT decode to an all-zero clear
    always_comb begin
        onehot = '0;
        for (int i = 0; i < ICOUNT; i++) onehot[i] = (32'(vec_q) == i);
    end

    always_comb begin
        state_d = state_q;
        ripl_d  = ripl_q;
        vec_d   = vec_q;
        clear_d = '0;
        ackv_d  = 1'b0;
        ackn_d  = '0;
        case (state_q)
            IDLE: if (eligible) begin
                ripl_d  = irq_number;
                vec_d   = irq_number;
                state_d = REQ;
            end
            REQ: if (EIC_IAck) begin
                ackv_d  = 1'b1;
                ackn_d  = vec_q;
                clear_d = onehot;
                state_d = ACK;
            end else if (!eligible) begin
                ripl_d  = '0;
                state_d = IDLE;
            end else if (irq_number != vec_q) begin
                ripl_d = irq_number;
                vec_d  = irq_number;
            end
            ACK: begin
                ripl_d  = '0;
                state_d = WAIT;
            end
            default: state_d = EIC_IAck ? WAIT : IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            ripl_q  <= '0;
            vec_q   <= '0;
            clear_q <= '0;
            ackv_q  <= 1'b0;
            ackn_q  <= '0;
        end else begin
            state_q <= state_d;
            ripl_q  <= ripl_d;
            vec_q   <= vec_d;
            clear_q <= clear_d;
            ackv_q  <= ackv_d;
            ackn_q  <= ackn_d;
        end
    end

    assign EIC_RIPL   = ripl_q;
    assign EIC_Vector = vec_q;
    assign irq_clear  = clear_q;
    assign ack_valid  = ackv_q;
    assign ack_number = ackn_q;

endmodule

// File: tb/tb_mfp_eic_ack_decoder.sv
// tb_mfp_eic_ack_decoder: directed handshake scenarios checked every cycle against
// a request/acknowledge model, plus literal expectations for key cycles.
module tb_mfp_eic_ack_decoder;

    localparam int ICOUNT = 64;
    localparam int VW     = 6;

    logic              CLK, RESETn, irq_detect, EIC_IAck;
    logic [VW-1:0]     irq_number, EIC_IPL;
    logic [VW-1:0]     EIC_RIPL, EIC_Vector, ack_number;
    logic [ICOUNT-1:0] irq_clear;
    logic              ack_valid;

    int vectors = 0;
    int miscompares = 0;

    mfp_eic_ack_decoder #(.ICOUNT(ICOUNT), .VW(VW)) dut (
        .CLK(CLK), .RESETn(RESETn), .irq_detect(irq_detect), .irq_number(irq_number),
        .EIC_IPL(EIC_IPL), .EIC_IAck(EIC_IAck), .EIC_RIPL(EIC_RIPL),
        .EIC_Vector(EIC_Vector), .irq_clear(irq_clear), .ack_valid(ack_valid),
        .ack_number(ack_number)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: shown request (0 = none), shown vector, number being acked this
    // cycle (-1 = none), and whether we are waiting for IAck to be released.
    int m_ripl = 0, m_vec = 0, m_ack = -1;
    bit m_busy = 0;

    always @(negedge CLK) begin
        int  n_ripl, n_vec, n_ack;
        bit  n_busy, elig;
        logic [63:0] exp_clr;
        if (!RESETn) begin
            m_ripl = 0; m_vec = 0; m_ack = -1; m_busy = 0;
        end
        exp_clr = (m_ack >= 0 && m_ack < ICOUNT) ? (64'd1 << m_ack) : 64'd0;
        chk("m_ripl", 64'(EIC_RIPL), 64'(m_ripl));
        chk("m_vector", 64'(EIC_Vector), 64'(m_vec));
        chk("m_ack_valid", 64'(ack_valid), 64'(m_ack >= 0));
        chk("m_ack_number", 64'(ack_number), (m_ack >= 0) ? 64'(m_ack) : 64'd0);
        chk("m_irq_clear", 64'(irq_clear), exp_clr);
        if (RESETn) begin
            elig = irq_detect && int'(irq_number) != 0 && int'(irq_number) > int'(EIC_IPL);
            n_ripl = m_ripl; n_vec = m_vec; n_ack = -1; n_busy = m_busy;
            if (m_ack >= 0) begin
                n_ripl = 0; n_busy = 1;
            end else if (m_busy) begin
                n_busy = EIC_IAck;
            end else if (m_ripl != 0) begin
                if (EIC_IAck) n_ack = m_vec;
                else if (!elig) n_ripl = 0;
                else begin n_ripl = int'(irq_number); n_vec = int'(irq_number); end
            end else if (elig) begin
                n_ripl = int'(irq_number); n_vec = int'(irq_number);
            end
            m_ripl = n_ripl; m_vec = n_vec; m_ack = n_ack; m_busy = n_busy;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int pulses;
        RESETn = 1'b0; irq_detect = 1'b0; irq_number = '0; EIC_IPL = '0; EIC_IAck = 1'b0;
        tick(2);
        chk("rst_ripl", 64'(EIC_RIPL), 64'd0);
        chk("rst_vector", 64'(EIC_Vector), 64'd0);
        chk("rst_clear", 64'(irq_clear), 64'd0);
        chk("rst_ack_valid", 64'(ack_valid), 64'd0);
        chk("rst_ack_number", 64'(ack_number), 64'd0);
        RESETn = 1'b1;
        tick();
        // basic request and acknowledge
        irq_detect = 1'b1; irq_number = 6'd5;
        tick();
        chk("t1_ripl", 64'(EIC_RIPL), 64'd5);
        chk("t1_vector", 64'(EIC_Vector), 64'd5);
        EIC_IAck = 1'b1;
        tick();
        chk("t1_clear", 64'(irq_clear), 64'h20);
        chk("t1_ack_valid", 64'(ack_valid), 64'd1);
        chk("t1_ack_number", 64'(ack_number), 64'd5);
        chk("t1_ripl_hold", 64'(EIC_RIPL), 64'd5);
        EIC_IAck = 1'b0; irq_detect = 1'b0;
        tick();
        chk("t1_ripl_drop", 64'(EIC_RIPL), 64'd0);
        chk("t1_clear_drop", 64'(irq_clear), 64'd0);
        tick();
        // preemption
        irq_detect = 1'b1; irq_number = 6'd5;
        tick();
        irq_number = 6'd12;
        tick();
        chk("t2_ripl", 64'(EIC_RIPL), 64'd12);
        EIC_IAck = 1'b1;
        tick();
        chk("t2_clear", 64'(irq_clear), 64'h1000);
        EIC_IAck = 1'b0; irq_detect = 1'b0;
        tick(2);
        // masking by IPL
        EIC_IPL = 6'd8; irq_detect = 1'b1; irq_number = 6'd5;
        tick(2);
        chk("t3_masked", 64'(EIC_RIPL), 64'd0);
        EIC_IPL = 6'd4;
        tick();
        chk("t3_unmasked", 64'(EIC_RIPL), 64'd5);
        EIC_IPL = 6'd5;
        tick();
        chk("t3_withdrawn", 64'(EIC_RIPL), 64'd0);
        tick();
        chk("t3_no_clear", 64'(irq_clear), 64'd0);
        chk("t3_still_masked", 64'(EIC_RIPL), 64'd0);
        irq_detect = 1'b0; EIC_IPL = '0;
        tick();
        // held acknowledge
        irq_detect = 1'b1; irq_number = 6'd9;
        tick();
        chk("t4_ripl", 64'(EIC_RIPL), 64'd9);
        EIC_IAck = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(ack_valid);
            if (i > 0) chk("t4_ripl_low", 64'(EIC_RIPL), 64'd0);
        end
        chk("t4_one_pulse", 64'(pulses), 64'd1);
        EIC_IAck = 1'b0;
        tick();
        chk("t4_not_yet", 64'(EIC_RIPL), 64'd0);
        tick();
        chk("t4_rerequest", 64'(EIC_RIPL), 64'd9);
        EIC_IAck = 1'b1;
        tick();
        chk("t4_clear", 64'(irq_clear), 64'h200);
        EIC_IAck = 1'b0; irq_detect = 1'b0;
        tick(3);
        // value frozen on acknowledge, then reset during ACK
        irq_detect = 1'b1; irq_number = 6'd7;
        tick();
        chk("t5_ripl", 64'(EIC_RIPL), 64'd7);
        EIC_IAck = 1'b1; irq_number = 6'd20;
        tick();
        chk("t5_ack_number", 64'(ack_number), 64'd7);
        chk("t5_clear", 64'(irq_clear), 64'h80);
        #2 RESETn = 1'b0;
        #1;
        chk("t6_rst_ripl", 64'(EIC_RIPL), 64'd0);
        chk("t6_rst_clear", 64'(irq_clear), 64'd0);
        chk("t6_rst_ack_valid", 64'(ack_valid), 64'd0);
        chk("t6_rst_ack_number", 64'(ack_number), 64'd0);
        chk("t6_rst_vector", 64'(EIC_Vector), 64'd0);
        @(posedge CLK);
        #1 RESETn = 1'b1; EIC_IAck = 1'b0; irq_detect = 1'b0;
        tick(2);
        chk("t6_idle", 64'(EIC_RIPL), 64'd0);
        irq_detect = 1'b1; irq_number = 6'd0;
        tick(3);
        chk("t6_line0", 64'(EIC_RIPL), 64'd0);
        chk("t6_line0_ack", 64'(ack_valid), 64'd0);
        irq_detect = 1'b0;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
